// File: rtl/fft_frame_assembler.sv
// fft_frame_assembler
// Receive-side frame parser: waits for a sync byte, packs little-endian payload
// bytes into WORD_SIZE samples, writes them to the sample RAM and validates a
// trailing XOR checksum before signalling o_frame_ready to the FFT controller.
// Any checksum mismatch or inter-byte timeout aborts the frame with a one-cycle
// o_error pulse. RAM words of an aborted frame are left stale on purpose; the
// consumer must only trust o_frame_ready.
module fft_frame_assembler #(
    parameter int                     FFT_SIZE       = 16,
    parameter int                     WORD_SIZE      = 16,
    parameter int                     DATA_LENGTH    = 8,
    parameter logic [DATA_LENGTH-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                     TIMEOUT_CYCLES = 100000
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic [DATA_LENGTH-1:0]                          i_byte,
    input  logic                                            i_byte_valid,
    input  logic                                            i_frame_ack,
    output logic                                            o_sample_we,
    output logic [((FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1)-1:0] o_sample_addr,
    output logic [WORD_SIZE-1:0]                            o_sample_data,
    output logic                                            o_frame_ready,
    output logic                                            o_busy,
    output logic                                            o_error
);

    localparam int BPW = WORD_SIZE / DATA_LENGTH;
    localparam int AW  = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0]  LAST_WORD = AW'(FFT_SIZE - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_READY   = 2'd3
    } state_t;

    // Running frame checksum is a plain XOR of all payload bytes.
    function automatic logic [DATA_LENGTH-1:0] f_csum_next(
        input logic [DATA_LENGTH-1:0] csum,
        input logic [DATA_LENGTH-1:0] data
    );
        return csum ^ data;
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [BCW-1:0]         r_byte_cnt;
    logic [AW-1:0]          r_word_idx;
    logic [WORD_SIZE-1:0]   r_word_buf;
    logic [DATA_LENGTH-1:0] r_csum;
    logic [TW-1:0]          r_tmo_cnt;
    logic                   r_sample_we;
    logic [AW-1:0]          r_sample_addr;
    logic [WORD_SIZE-1:0]   r_sample_data;
    logic                   r_frame_ready;
    logic                   r_busy;
    logic                   r_error;

    logic                   w_start;
    logic                   w_take_byte;
    logic                   w_word_done;
    logic                   w_good;
    logic                   w_err;
    logic                   w_ack;
    logic                   w_tmo_clr;
    logic                   w_tmo_inc;
    logic [WORD_SIZE-1:0]   w_word;

    // Merge the incoming byte into its lane of the word being assembled.
    always_comb begin
        w_word = r_word_buf;
        w_word[int'(r_byte_cnt) * DATA_LENGTH +: DATA_LENGTH] = i_byte;
    end

    // Next-state and control decode for the frame parser.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_take_byte  = 1'b0;
        w_word_done  = 1'b0;
        w_good       = 1'b0;
        w_err        = 1'b0;
        w_ack        = 1'b0;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_byte_valid && (i_byte == SYNC_BYTE)) begin
                    w_next_state = ST_PAYLOAD;
                    w_start      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (i_byte_valid) begin
                    w_take_byte = 1'b1;
                    w_tmo_clr   = 1'b1;
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_word_done = 1'b1;
                        if (r_word_idx == LAST_WORD) begin
                            w_next_state = ST_CHECK;
                        end else begin
                            w_next_state = ST_PAYLOAD;
                        end
                    end else begin
                        w_word_done = 1'b0;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_CHECK: begin
                if (i_byte_valid) begin
                    w_tmo_clr = 1'b1;
                    if (i_byte == r_csum) begin
                        w_good       = 1'b1;
                        w_next_state = ST_READY;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_READY: begin
                // Bytes are ignored here; an ack takes priority over any byte.
                if (i_frame_ack) begin
                    w_ack        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_READY;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Parser state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte/word counters, word assembly buffer and running checksum.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_word_buf <= '0;
            r_csum     <= '0;
        end else if (w_start) begin
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_word_buf <= '0;
            r_csum     <= '0;
        end else if (w_take_byte) begin
            r_csum     <= f_csum_next(r_csum, i_byte);
            r_word_buf <= w_word;
            if (w_word_done) begin
                r_byte_cnt <= '0;
                r_word_idx <= r_word_idx + AW'(1);
            end else begin
                r_byte_cnt <= r_byte_cnt + BCW'(1);
            end
        end
    end

    // Inter-byte timeout counter, only meaningful while a frame is in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_start || w_tmo_clr || w_err) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_inc) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // Registered outputs: RAM write port, ready level, busy level, error pulse.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sample_we   <= 1'b0;
            r_sample_addr <= '0;
            r_sample_data <= '0;
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_sample_we <= w_word_done;
            r_error     <= w_err;
            r_busy      <= (w_next_state == ST_PAYLOAD) || (w_next_state == ST_CHECK);
            if (w_word_done) begin
                r_sample_addr <= r_word_idx;
                r_sample_data <= w_word;
            end
            if (w_good) begin
                r_frame_ready <= 1'b1;
            end else if (w_ack) begin
                r_frame_ready <= 1'b0;
            end
        end
    end

    assign o_sample_we   = r_sample_we;
    assign o_sample_addr = r_sample_addr;
    assign o_sample_data = r_sample_data;
    assign o_frame_ready = r_frame_ready;
    assign o_busy        = r_busy;
    assign o_error       = r_error;

endmodule
